od_line_driver: RTL
===================

Name: od_line_driver

Overview:
- Output-side counterpart to the input debouncer: drives one open-drain bus line (SCL or SDA) from a requested level, enforces minimum hold and settle times in ck_enable ticks, and verifies release through the debounced readback.
- Sits between the I2C bit-level controller and the pad.
  - The pad pulls low while oe=1.
  - line_in comes from the debouncer on the same pad.
- Detects clock stretching and stuck-low faults.

Parameters:
- HOLD_TICKS, 4: minimum ck_enable ticks a requested level is held before completion; legal range 1..2^TICK_W-1.
- SETTLE_TICKS, 2: ticks after release before line_in is sampled; legal range 1..2^TICK_W-1.
- TIMEOUT_TICKS, 200: maximum ticks to wait for the line to rise after settle; legal range 1..2^TICK_W-1.
- TICK_W, 8: width of the tick counter.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-low.
- ck_enable, input, 1: timing tick; all counters advance only when it is 1.
- req_valid, input, 1: a level request is present.
- req_level, input, 1: requested line level; 0 = pull low, 1 = release.
- req_ready, output, 1: high only in IDLE.
- line_in, input, 1: debounced readback of the pad.
- oe, output, 1: registered; 1 = drive the pad low.
- busy, output, 1: high whenever the state is not IDLE.
- stretch, output, 1: registered; high while in WAIT_HIGH.
- done, output, 1: one-clk pulse when a request completes successfully.
- fault, output, 1: one-clk pulse on timeout.

Behaviour:
- Reset values: state=IDLE, oe=0 (line released), cnt=0, stretch=0, done=0, fault=0. Because state is IDLE, req_ready=1 and busy=0.
- A request is accepted in the cycle where req_valid & req_ready.
  - On acceptance: latch lvl <= req_level, oe <= ~req_level, cnt <= HOLD_TICKS-1, state <= HOLD.
  - A request is accepted independent of ck_enable.
- HOLD:
  - On each ck_enable with cnt != 0: cnt decrements.
  - On ck_enable with cnt == 0:
    - If lvl=0: state <= IDLE, done <= 1.
    - If lvl=1: cnt <= SETTLE_TICKS-1, state <= SETTLE.
  - line_in is ignored in HOLD.
- SETTLE: same countdown. On ck_enable with cnt == 0, sample line_in:
  - line_in=1: state <= IDLE, done <= 1.
  - line_in=0: cnt <= TIMEOUT_TICKS-1, stretch <= 1, state <= WAIT_HIGH.
- WAIT_HIGH: evaluated each cycle.
  - If line_in=1 (any cycle, not tick-gated): stretch <= 0, done <= 1, state <= IDLE.
  - Else, on ck_enable with cnt == 0: stretch <= 0, fault <= 1, state <= IDLE.
  - Else, on ck_enable: cnt decrements.
  - If line_in=1 and the timeout coincide in the same cycle, the rise wins: done, not fault.
- oe holds its value through completion and fault; it changes only on acceptance or reset.
  - A fault leaves oe=0; the line stays released.
- done and fault are mutually exclusive and last exactly one clk.
- Latency with ck_enable tied 1 (accept at cycle 0; oe valid from cycle 1):
  - req_level=0: done high in cycle HOLD_TICKS+1; req_ready high in the same cycle.
  - req_level=1 and line high: done in cycle HOLD_TICKS+SETTLE_TICKS+1.
- Back-to-back: a new request may be accepted in the cycle done or fault is high (state already IDLE). Throughput is one request per HOLD_TICKS+1 clks minimum.
- Requesting the level already driven is legal; the full timing sequence is re-run.
- Reset mid-operation: all outputs return to reset values immediately; any pending done or fault is lost.

Decomposition:
- Shared package (i2c_pkg):
  - State encoding constants IDLE=2'd0, HOLD=2'd1, SETTLE=2'd2, WAIT_HIGH=2'd3.
  - Default tick constants shared with the debouncer and bit controller.
- One sub-module, tick_counter: loadable down-counter with ck_enable gating and a zero flag.
  - Load has priority over decrement.
- The FSM stays in od_line_driver.

Test Plan:
- Reset, low hold:
  - Stimulus: rst low mid-HOLD; then, after rst release, with ck_enable=1, HOLD_TICKS=4, request level 0 at cycle 0.
  - Response: oe=0 and req_ready=1 during reset. oe=1 at cycle 1; done at cycle 5; oe stays 1.
- Release, no stretch:
  - Stimulus: with oe=1, request level 1; line_in rises 1 cycle later.
  - Response: oe=0 at cycle 1; done at cycle 7 (4+2+1); stretch never set.
- Clock stretch:
  - Stimulus: request level 1 with line_in held 0 for 20 cycles past settle, then 1.
  - Response: stretch=1 from cycle 7 until the rise; done in the rise cycle; fault=0.
- Timeout:
  - Stimulus: TIMEOUT_TICKS=10, line_in stuck 0.
  - Response: fault pulses once at cycle 17 (7+10); stretch drops; oe=0; state IDLE.
- Tick gating:
  - Stimulus: ck_enable high 1 cycle in 4, level-0 request.
  - Response: done only after the 5th tick; busy remains 1 throughout.
  - Stimulus: req_valid held continuously.
  - Response: the next request is accepted in the done cycle.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: line-driver state encoding
// and default tick constants for the pad-side blocks.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD      = 2'd1,
    SETTLE    = 2'd2,
    WAIT_HIGH = 2'd3
  } od_state_t;

  localparam int DEF_TICK_W        = 8;
  localparam int DEF_HOLD_TICKS    = 4;
  localparam int DEF_SETTLE_TICKS  = 2;
  localparam int DEF_TIMEOUT_TICKS = 200;

  function automatic logic [DEF_TICK_W-1:0] tick_load(
    input int ticks
  );
    return DEF_TICK_W'(ticks - 1);
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Loadable down-counter advancing on ck_enable;
// load wins over decrement, and it parks at zero.
module tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ck_enable,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec_en,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec_en && ck_enable && !zero) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/od_line_driver.sv
// Open-drain line driver: holds a requested level for a
// minimum time, then confirms release via debounced readback.
module od_line_driver
  import i2c_pkg::*;
#(
  parameter int HOLD_TICKS    = DEF_HOLD_TICKS,
  parameter int SETTLE_TICKS  = DEF_SETTLE_TICKS,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int TICK_W        = DEF_TICK_W
) (
  input  logic clk,
  input  logic rst,
  input  logic ck_enable,
  input  logic req_valid,
  input  logic req_level,
  output logic req_ready,
  input  logic line_in,
  output logic oe,
  output logic busy,
  output logic stretch,
  output logic done,
  output logic fault
);

  localparam logic [TICK_W-1:0] HOLD_LD =
    TICK_W'(HOLD_TICKS - 1);
  localparam logic [TICK_W-1:0] SETTLE_LD =
    TICK_W'(SETTLE_TICKS - 1);
  localparam logic [TICK_W-1:0] TO_LD =
    TICK_W'(TIMEOUT_TICKS - 1);

  od_state_t state_q, state_d;

  logic              lvl_q, lvl_d;
  logic              oe_d;
  logic              stretch_d;
  logic              done_d;
  logic              fault_d;
  logic              load;
  logic [TICK_W-1:0] load_val;
  logic [TICK_W-1:0] cnt;
  logic              zero;
  logic              tick_end;

  tick_counter #(
    .W (TICK_W)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .ck_enable (ck_enable),
    .load      (load),
    .load_val  (load_val),
    .dec_en    (busy),
    .cnt       (cnt),
    .zero      (zero)
  );

  assign req_ready = (state_q == IDLE);
  assign busy      = !req_ready;
  assign tick_end  = ck_enable && zero;

  always_comb begin
    state_d   = state_q;
    lvl_d     = lvl_q;
    oe_d      = oe;
    stretch_d = stretch;
    done_d    = 1'b0;
    fault_d   = 1'b0;
    load      = 1'b0;
    load_val  = '0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (req_valid) begin
          lvl_d    = req_level;
          oe_d     = !req_level;
          load     = 1'b1;
          load_val = HOLD_LD;
          state_d  = HOLD;
        end
      end
      (state_q == HOLD): begin
        if (tick_end) begin
          if (!lvl_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            load     = 1'b1;
            load_val = SETTLE_LD;
            state_d  = SETTLE;
          end
        end
      end
      (state_q == SETTLE): begin
        if (tick_end) begin
          if (line_in) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            load      = 1'b1;
            load_val  = TO_LD;
            stretch_d = 1'b1;
            state_d   = WAIT_HIGH;
          end
        end
      end
      (state_q == WAIT_HIGH): begin
        // a rise in the timeout cycle still counts as success
        if (line_in) begin
          stretch_d = 1'b0;
          done_d    = 1'b1;
          state_d   = IDLE;
        end else if (tick_end) begin
          stretch_d = 1'b0;
          fault_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lvl_q   <= 1'b1;
      oe      <= 1'b0;
      stretch <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      oe      <= oe_d;
      stretch <= stretch_d;
      done    <= done_d;
      fault   <= fault_d;
    end
  end

endmodule
